frame_xfer_decimator: RTL and testbench

Parametrised successor to the frame downsampler. It copies a completed camera frame out of the capture BRAM into the object-detection path, keeping only every (frame_skip+1)th frame (temporal decimation) and every (h_step+1)th pixel of every (v_step+1)th line (spatial decimation). It accounts for the BRAM read latency and obeys valid/ready backpressure from the consumer. It sits between the OV7670 capture BRAM read port and the object-detection frame store.

---
 rtl/frame_xfer_decimator.sv | 257 +++++++++++++++++++++++++
 tb/tb_frame_xfer_decimator.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_xfer_decimator.sv
// Copies a finished capture frame out of BRAM with temporal and spatial
// decimation, tracking BRAM read latency and honouring consumer backpressure.
module frame_xfer_decimator #(
  parameter int ADDR_W   = 17,
  parameter int PIX_W    = 16,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int RD_LAT   = 2,
  parameter int SKIP_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [SKIP_W-1:0] frame_skip,
  input  logic [3:0]        h_step,
  input  logic [3:0]        v_step,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [PIX_W-1:0]  bram_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
  output logic              frame_done,
  output logic [SKIP_W-1:0] overrun_cnt
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = 4;
  localparam int PW    = $clog2(DEPTH);
  localparam int XW    = $clog2(H_ACTIVE + 16) + 1;
  localparam int YW    = $clog2(V_ACTIVE + 16) + 1;
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_XFER,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic              r_cap_last;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [SKIP_W-1:0] r_skip;
  logic [3:0]        r_h;
  logic [3:0]        r_v;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_rstep;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [ADDR_W-1:0] r_oaddr;
  logic [SKIP_W-1:0] r_ovr;
  logic              r_done;

  logic [CW-1:0]     r_infl;
  logic [CW-1:0]     r_fcnt;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [PIX_W-1:0]  r_mem_p [DEPTH];
  logic              r_mem_e [DEPTH];
  logic [RD_LAT-1:0] r_pend;
  logic [RD_LAT-1:0] r_peol;

  logic              w_cap_end;
  logic              w_fe;
  logic [4:0]        w_hinc;
  logic [4:0]        w_vinc;
  logic [XW-1:0]     w_xn;
  logic [YW-1:0]     w_yn;
  logic              w_wrap;
  logic              w_lastln;
  logic              w_space;
  logic              w_issue;
  logic              w_arr;
  logic              w_valid;
  logic              w_pop;
  logic              w_drained;
  logic              w_busy;
  logic              w_armctx;
  logic              w_afe;
  logic              w_go;
  logic              w_ovr_ev;

  assign w_cap_end = (cap_addr == LAST_A);
  assign w_fe      = w_cap_end && !r_cap_last;

  assign w_hinc   = {1'b0, r_h} + 5'd1;
  assign w_vinc   = {1'b0, r_v} + 5'd1;
  assign w_xn     = r_x + XW'(w_hinc);
  assign w_yn     = r_y + YW'(w_vinc);
  assign w_wrap   = (w_xn >= XW'(H_ACTIVE));
  assign w_lastln = (w_yn >= YW'(V_ACTIVE));

  // Reads in flight reserve FIFO slots so an arrival never overflows.
  assign w_space = ((r_fcnt + r_infl) < CW'(DEPTH));
  assign w_issue = (r_state == S_XFER) && w_space;
  assign w_arr   = r_pend[RD_LAT-1];
  assign w_valid = (r_fcnt != '0);
  assign w_pop   = w_valid && out_ready;

  assign w_drained = (r_infl == '0) && (r_fcnt == '0);
  assign w_busy    = (r_state == S_XFER) || (r_state == S_DRAIN);

  // The drain-exit cycle behaves like ARM for frame-end handling.
  assign w_armctx = enable &&
    ((r_state == S_ARM) ||
     ((r_state == S_DRAIN) && w_drained));
  assign w_afe    = w_armctx && w_fe;
  assign w_go     = w_afe && (r_skip_cnt == r_skip);
  assign w_ovr_ev = w_fe && w_busy && !w_afe;

  function automatic logic [PW-1:0] ptr_nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cap_last  <= 1'b0;
      r_skip_cnt  <= '0;
      r_skip      <= '0;
      r_h         <= '0;
      r_v         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_row       <= '0;
      r_rstep     <= '0;
      r_bram_addr <= '0;
      r_oaddr     <= '0;
      r_ovr       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_cap_last <= w_cap_end;
      r_done     <= 1'b0;
      if (w_ovr_ev && (r_ovr != '1))
        r_ovr <= r_ovr + 1'b1;
      if (w_pop)
        r_oaddr <= r_oaddr + 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state    <= S_ARM;
            r_skip_cnt <= '0;
          end
        end
        S_ARM: begin
          if (!enable)
            r_state <= S_IDLE;
          else if (w_fe && !w_go)
            r_skip_cnt <= r_skip_cnt + 1'b1;
        end
        S_XFER: begin
          if (w_issue) begin
            if (w_wrap) begin
              r_x         <= '0;
              r_y         <= w_yn;
              r_row       <= r_row + r_rstep;
              r_bram_addr <= r_row + r_rstep;
              if (w_lastln) begin
                r_state     <= S_DRAIN;
                r_bram_addr <= '0;
              end
            end else begin
              r_x         <= w_xn;
              r_bram_addr <= r_bram_addr + ADDR_W'(w_hinc);
            end
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_state <= enable ? S_ARM : S_IDLE;
            if (w_afe && !w_go)
              r_skip_cnt <= r_skip_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_go) begin
        r_state     <= S_XFER;
        r_skip_cnt  <= '0;
        r_skip      <= frame_skip;
        r_h         <= h_step;
        r_v         <= v_step;
        r_rstep     <= ADDR_W'((int'(v_step) + 1) * H_ACTIVE);
        r_x         <= '0;
        r_y         <= '0;
        r_row       <= '0;
        r_bram_addr <= '0;
        r_oaddr     <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend <= '0;
      r_peol <= '0;
      r_infl <= '0;
      r_fcnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_p[i] <= '0;
        r_mem_e[i] <= 1'b0;
      end
    end else begin
      r_pend[0] <= w_issue;
      r_peol[0] <= w_issue && w_wrap;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pend[i] <= r_pend[i-1];
        r_peol[i] <= r_peol[i-1];
      end

      unique case ({w_issue, w_arr})
        2'b10:   r_infl <= r_infl + 1'b1;
        2'b01:   r_infl <= r_infl - 1'b1;
        default: r_infl <= r_infl;
      endcase

      if (w_arr) begin
        r_mem_p[r_wp] <= bram_data;
        r_mem_e[r_wp] <= r_peol[RD_LAT-1];
        r_wp          <= ptr_nxt(r_wp);
      end
      if (w_pop)
        r_rp <= ptr_nxt(r_rp);

      unique case ({w_arr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign bram_addr   = r_bram_addr;
  assign out_addr    = r_oaddr;
  assign out_valid   = w_valid;
  assign out_pixel   = w_valid ? r_mem_p[r_rp] : '0;
  assign out_eol     = w_valid && r_mem_e[r_rp];
  assign out_sof     = w_valid && (r_oaddr == '0);
  assign busy        = w_busy;
  assign frame_done  = r_done;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_frame_xfer_decimator.sv
// Directed bench for frame_xfer_decimator on a reduced 20x12 frame with a
// three-cycle BRAM, scored against a queue of expected beats.
module tb_frame_xfer_decimator;

  localparam int AW = 17;
  localparam int PW = 16;
  localparam int H  = 20;
  localparam int V  = 12;
  localparam int RL = 3;
  localparam int SW = 16;
  localparam logic [AW-1:0] LASTA = AW'(H * V - 1);

  logic          clk;
  logic          resetn;
  logic          enable;
  logic [AW-1:0] cap_addr;
  logic [SW-1:0] frame_skip;
  logic [3:0]    h_step;
  logic [3:0]    v_step;
  logic [AW-1:0] bram_addr;
  logic [PW-1:0] bram_data;
  logic [AW-1:0] out_addr;
  logic [PW-1:0] out_pixel;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic          busy;
  logic          frame_done;
  logic [SW-1:0] overrun_cnt;

  frame_xfer_decimator #(
    .ADDR_W(AW), .PIX_W(PW), .H_ACTIVE(H),
    .V_ACTIVE(V), .RD_LAT(RL), .SKIP_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .cap_addr(cap_addr), .frame_skip(frame_skip),
    .h_step(h_step), .v_step(v_step),
    .bram_addr(bram_addr), .bram_data(bram_data),
    .out_addr(out_addr), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol),
    .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [PW-1:0] p;
    logic          s;
    logic          e;
  } beat_t;

  beat_t exp_q[$];
  int n_chk, n_err;
  int cyc, done_cnt, xfer_cnt;
  int acc_cnt, eol_cnt, stalls;
  int start_cyc, first_v_cyc, first_acc, last_acc;
  int m_left;
  logic [AW-1:0] last_addr;
  logic [PW-1:0] got_pix [256];
  bit sb_en, rnd_rdy, hold_v, busy_q;
  logic [AW+PW+2:0] held;

  function automatic logic [PW-1:0] pix(input int a);
    return PW'(a * 7 + 4660);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= pix(int'(bram_addr));
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_data = pipe[RL-1];

  task automatic chk(input string nm, input longint got,
                     input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic monitor();
    beat_t e, g;
    cyc++;
    if (resetn && sb_en) begin
      if (busy && !busy_q) begin
        xfer_cnt++;
        start_cyc   = cyc;
        first_v_cyc = -1;
      end
      if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (hold_v) begin
        n_chk++;
        if ({out_valid, out_addr, out_pixel, out_sof, out_eol} != held) begin
          n_err++;
          $display("FAIL hold got %h want %h",
            {out_valid, out_addr, out_pixel, out_sof, out_eol}, held);
        end
      end
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        g = '{out_addr, out_pixel, out_sof, out_eol};
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat got %h want none", g);
        end else begin
          e = exp_q.pop_front();
          if (g != e) begin
            n_err++;
            $display("FAIL beat got a=%0d p=%h s=%b e=%b want a=%0d p=%h s=%b e=%b",
              g.a, g.p, g.s, g.e, e.a, e.p, e.s, e.e);
          end
        end
        if (out_addr == '0) first_acc = cyc;
        last_acc  = cyc;
        acc_cnt++;
        last_addr = out_addr;
        if (out_eol) eol_cnt++;
        got_pix[out_addr[7:0]] = out_pixel;
      end else if (out_valid) begin
        hold_v = 1'b1;
        stalls++;
        held = {out_valid, out_addr, out_pixel, out_sof, out_eol};
      end
      if (frame_done) done_cnt++;
    end else begin
      hold_v = 1'b0;
    end
    busy_q = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic pulse_fe(input int len);
    tick();
    cap_addr = LASTA;
    repeat (len) tick();
    cap_addr = '0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 5000) begin
      tick();
      n++;
    end
    chk("done_timeout", longint'(done_cnt > base), 1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 50) begin
      tick();
      n++;
    end
    chk("busy_rise", longint'(busy), 1);
  endtask

  task automatic load_frame(input int h, input int v);
    int k;
    k = 0;
    for (int y = 0; y < V; y += v + 1)
      for (int x = 0; x < H; x += h + 1) begin
        exp_q.push_back('{AW'(k), pix(y * H + x),
                          k == 0, (x + h + 1) >= H});
        k++;
      end
  endtask

  task automatic model_fe(output bit x);
    if (m_left == 0) begin
      load_frame(int'(h_step), int'(v_step));
      m_left = int'(frame_skip);
      x = 1'b1;
    end else begin
      m_left--;
      x = 1'b0;
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; eol_cnt = 0; stalls = 0;
    first_acc = 0; last_acc = 0; last_addr = '0;
  endtask

  task automatic frame(input int h, input int v,
                       input bit rnd, input int fe_len);
    bit x;
    int bd, bx;
    h_step = 4'(h);
    v_step = 4'(v);
    rnd_rdy = rnd;
    if (!rnd) out_ready = 1'b1;
    clear_stats();
    bd = done_cnt;
    bx = xfer_cnt;
    model_fe(x);
    pulse_fe(fe_len);
    if (x) wait_done(bd);
    else repeat (12) tick();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("xfer_count", xfer_cnt - bx, longint'(x));
    chk("done_count", done_cnt - bd, longint'(x));
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic main_seq();
    logic [7:0] mask;
    bit x;
    int bx, bd;
    resetn = 1'b0; enable = 1'b0; cap_addr = '0;
    frame_skip = '0; h_step = '0; v_step = '0;
    out_ready = 1'b1; m_left = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
      |{bram_addr, out_addr, out_pixel, out_valid, out_sof,
        out_eol, busy, frame_done, overrun_cnt}, 0);
    tick();
    resetn = 1'b1;
    sb_en = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    frame(0, 0, 1'b0, 3);
    chk("full_beats", acc_cnt, 240);
    chk("full_last", last_addr, 239);
    chk("full_eol", eol_cnt, 12);
    chk("first_lat", first_v_cyc - start_cyc, 4);
    chk("thruput", last_acc - first_acc, 239);

    frame(1, 1, 1'b0, 1);
    chk("hv1_beats", acc_cnt, 60);
    chk("hv1_last", last_addr, 59);
    chk("hv1_eol", eol_cnt, 6);
    chk("hv1_pix15", got_pix[15], 5010);
    chk("hv1_pix59", got_pix[59], 6186);

    frame(2, 0, 1'b0, 1);
    chk("h2_beats", acc_cnt, 84);
    chk("h2_last", last_addr, 83);
    chk("h2_eol", eol_cnt, 12);
    chk("h2_pix6", got_pix[6], 4786);
    chk("h2_pix83", got_pix[83], 6326);

    frame_skip = 16'd3;
    h_step = 4'd3;
    v_step = 4'd3;
    mask = '0;
    for (int i = 1; i <= 8; i++) begin
      bx = xfer_cnt;
      bd = done_cnt;
      model_fe(x);
      pulse_fe(1);
      if (x) wait_done(bd);
      else repeat (12) tick();
      repeat (3) tick();
      if (xfer_cnt != bx) mask[i-1] = 1'b1;
      chk("skip_model", xfer_cnt - bx, longint'(x));
    end
    chk("skip_mask", mask, 8'h11);
    chk("skip_queue", exp_q.size(), 0);
    frame_skip = '0;

    frame(0, 0, 1'b1, 1);
    chk("rnd_beats", acc_cnt, 240);
    chk("rnd_last", last_addr, 239);
    chk("rnd_stalled", longint'(stalls > 0), 1);

    clear_stats();
    bx = xfer_cnt;
    bd = done_cnt;
    model_fe(x);
    pulse_fe(1);
    wait_busy();
    repeat (5) tick();
    pulse_fe(1);
    wait_done(bd);
    repeat (30) tick();
    chk("ovr_cnt", overrun_cnt, 1);
    chk("ovr_xfers", xfer_cnt - bx, 1);
    chk("ovr_idle", busy, 0);
    chk("ovr_beats", acc_cnt, 240);

    model_fe(x);
    pulse_fe(1);
    wait_busy();
    repeat (20) tick();
    sb_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_outs",
      |{bram_addr, out_addr, out_pixel, out_valid, out_sof,
        out_eol, busy, frame_done, overrun_cnt}, 0);
    repeat (2) tick();
    resetn = 1'b1;
    exp_q.delete();
    m_left = 0;
    sb_en = 1'b1;
    repeat (3) tick();
    frame(0, 0, 1'b0, 1);
    chk("post_beats", acc_cnt, 240);
    chk("post_last", last_addr, 239);
    chk("post_ovr", overrun_cnt, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    done_cnt = 0; xfer_cnt = 0;
    first_v_cyc = -1; start_cyc = 0;
    sb_en = 1'b0; rnd_rdy = 1'b0;
    hold_v = 1'b0; busy_q = 1'b0;
    clear_stats();
    fork
      begin
        forever begin
          @(negedge clk);
          monitor();
        end
      end
      begin
        main_seq();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
